// File: rtl/qr_result_drain_pkg.sv
// rtl/qr_result_drain_pkg.sv - shared constants, widths and state type for the QR result drain
package qr_result_drain_pkg;

  localparam int OUT_WIDTH = 12;

  localparam int R_ROW = 8;
  localparam int R_COL = 4;
  localparam int Q_ROW = 8;
  localparam int Q_COL = 8;

  localparam int R_LEN = R_ROW * R_COL;
  localparam int Q_LEN = Q_ROW * Q_COL;

  localparam int ROW_AW   = 3;
  localparam int R_COL_AW = 2;
  localparam int Q_COL_AW = 3;

  localparam int R_AW = ROW_AW + R_COL_AW;
  localparam int Q_AW = ROW_AW + Q_COL_AW;

  // One counter walks both matrices, so it is sized for the larger one.
  localparam int CNT_W = Q_AW;

  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(R_LEN - 1);
  localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(Q_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DRAIN_R,
    DRAIN_Q,
    DONE
  } state_t;

endpackage

// File: rtl/qr_result_drain_if.sv
// rtl/qr_result_drain_if.sv - write-side capture and result-stream signals of the QR result drain
interface qr_result_drain_if;
  import qr_result_drain_pkg::*;

  logic                 start;
  logic                 qr_valid;

  logic                 wr_R;
  logic [OUT_WIDTH-1:0] wr_R_data;
  logic [ROW_AW-1:0]    wr_R_row_addr;
  logic [R_COL_AW-1:0]  wr_R_col_addr;

  logic                 wr_Q;
  logic [OUT_WIDTH-1:0] wr_Q_data;
  logic [ROW_AW-1:0]    wr_Q_row_addr;
  logic [Q_COL_AW-1:0]  wr_Q_col_addr;

  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_sel;
  logic [2:0]           out_row;
  logic [2:0]           out_col;
  logic                 out_last;
  logic                 done;
  logic                 overrun;

  modport slave (
    input  start, qr_valid,
    input  wr_R, wr_R_data, wr_R_row_addr, wr_R_col_addr,
    input  wr_Q, wr_Q_data, wr_Q_row_addr, wr_Q_col_addr,
    input  out_ready,
    output out_valid, out_data, out_sel, out_row, out_col, out_last,
    output done, overrun
  );

  modport master (
    output start, qr_valid,
    output wr_R, wr_R_data, wr_R_row_addr, wr_R_col_addr,
    output wr_Q, wr_Q_data, wr_Q_row_addr, wr_Q_col_addr,
    output out_ready,
    input  out_valid, out_data, out_sel, out_row, out_col, out_last,
    input  done, overrun
  );

endinterface

// File: rtl/qr_mat_store.sv
// rtl/qr_mat_store.sv - flat register array with one write port, bulk clear and combinational read
module qr_mat_store #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Clear wins over a same-cycle write so a restart never keeps a stale element.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qr_result_drain.sv
// rtl/qr_result_drain.sv - captures qr_cordic R/Q writes and streams R then Q row-major on a valid/ready port
module qr_result_drain
  import qr_result_drain_pkg::*;
(
  input logic              clk,
  input logic              rst,
  qr_result_drain_if.slave bus
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 out_valid_r;
  logic                 done_r;
  logic                 overrun_r;

  logic                 capturing;
  logic                 r_we;
  logic                 q_we;
  logic                 any_wr;
  logic                 hs;
  logic                 in_q;
  logic [OUT_WIDTH-1:0] r_rdata;
  logic [OUT_WIDTH-1:0] q_rdata;

  assign capturing = (state == CAPTURE);
  assign any_wr    = bus.wr_R | bus.wr_Q;
  assign r_we      = bus.wr_R & capturing & ~bus.start;
  assign q_we      = bus.wr_Q & capturing & ~bus.start;
  assign hs        = out_valid_r & bus.out_ready;
  assign in_q      = (state == DRAIN_Q);

  qr_mat_store #(
    .DEPTH (R_LEN),
    .WIDTH (OUT_WIDTH),
    .AW    (R_AW)
  ) u_r_store (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.start),
    .we    (r_we),
    .waddr ({bus.wr_R_row_addr, bus.wr_R_col_addr}),
    .wdata (bus.wr_R_data),
    .raddr (cnt[R_AW-1:0]),
    .rdata (r_rdata)
  );

  qr_mat_store #(
    .DEPTH (Q_LEN),
    .WIDTH (OUT_WIDTH),
    .AW    (Q_AW)
  ) u_q_store (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.start),
    .we    (q_we),
    .waddr ({bus.wr_Q_row_addr, bus.wr_Q_col_addr}),
    .wdata (bus.wr_Q_data),
    .raddr (cnt),
    .rdata (q_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else if (bus.start) begin
      state       <= CAPTURE;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (any_wr && !capturing) begin
        overrun_r <= 1'b1;
      end
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        CAPTURE: begin
          if (bus.qr_valid) begin
            state       <= DRAIN_R;
            cnt         <= '0;
            out_valid_r <= 1'b1;
          end
        end
        DRAIN_R: begin
          if (hs) begin
            if (cnt == R_LAST) begin
              state <= DRAIN_Q;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN_Q: begin
          if (hs) begin
            if (cnt == Q_LAST) begin
              state       <= DONE;
              cnt         <= '0;
              out_valid_r <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Element fields are decoded from the counter and forced to zero when no beat is offered.
  always_comb begin
    bus.out_data = '0;
    bus.out_sel  = 1'b0;
    bus.out_row  = '0;
    bus.out_col  = '0;
    bus.out_last = 1'b0;
    if (out_valid_r) begin
      if (in_q) begin
        bus.out_data = q_rdata;
        bus.out_sel  = 1'b1;
        bus.out_row  = cnt[Q_AW-1:Q_COL_AW];
        bus.out_col  = cnt[Q_COL_AW-1:0];
        bus.out_last = (cnt == Q_LAST);
      end else begin
        bus.out_data = r_rdata;
        bus.out_row  = cnt[R_AW-1:R_COL_AW];
        bus.out_col  = {1'b0, cnt[R_COL_AW-1:0]};
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.done      = done_r;
  assign bus.overrun   = overrun_r;

endmodule
